step_phase_driver: RTL and testbench
====================================

Name: step_phase_driver

Overview:
- Downstream consumer of the speed stage's step_pulse square wave. Each rising edge of step_pulse is one step tick.
- Drives a 4-wire unipolar stepper through an 8-entry half-step phase table.
- Executes move commands of N ticks through a valid/ready handshake and tracks absolute position in half-step units.
- Sits between the speed/counter stage and the coil driver pins.

Parameters:
- POS_W, 16, width of the signed position counter (half-step units).
- STEPS_W, 16, width of the cmd_steps move length.
- HOLD_EN, 1, when 1 coils stay energised at the current phase while idle and enabled; when 0 coils are 0000 when idle.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- step_pulse  in  1  speed-stage square wave, same clock domain; rising edge = one tick
- enable  in  1  driver enable; low aborts any move and de-energises the coils
- dir  in  1  1 = forward (phase index increments), 0 = reverse; latched at command accept
- half_step  in  1  1 = half-step (index ±1), 0 = full-step (index ±2); latched at command accept
- cmd_valid  in  1  move request
- cmd_ready  out  1  block can accept a command
- cmd_steps  in  STEPS_W  number of ticks to execute, unsigned
- busy  out  1  move in progress
- done  out  1  one-cycle pulse when a move completes normally
- position  out  POS_W  signed two's-complement position, half-step units
- coils  out  4  {A, B, A_n, B_n} coil enables

Behaviour:
- Reset (rst sampled low at posedge clk), applied to all of the following:
  - state IDLE, phase index 0
  - position 0, remaining-step count 0
  - busy 0, done 0, coils 0000
  - step_pulse history register cleared
  - cmd_ready is 0 while rst is low.
- Reset mid-move: abort immediately, no done pulse, position returns to 0.
- Tick detection:
  - tick = step_pulse & ~step_pulse_q, where step_pulse_q is a 1-cycle delayed copy.
  - No synchroniser, because the input is in the same domain.
  - Phase, position and remaining count update at the same clock edge that first samples step_pulse high.
- Phase table (index: coils):
  - 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001
  - Index arithmetic is modulo 8 (7+1→0, 0−1→7; full-step 6+2→0, 1−2→7).
  - Full-step keeps parity: even index gives wave drive, odd index gives two-phase-on drive.
- Position update per tick:
  - +1/−1 in half-step mode, +2/−2 in full-step mode.
  - Wraps modulo 2^POS_W with no saturation (e.g. 0x7FFF+1 → 0x8000).
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - cmd_ready = enable.
  - Accept occurs when cmd_valid & cmd_ready. On accept, latch dir, half_step and cmd_steps.
  - If cmd_steps == 0, go directly to DONE.
  - Otherwise go to RUN with busy=1 from the next cycle.
  - Ticks in IDLE are ignored: no phase or position change.
- RUN:
  - cmd_ready=0 and busy=1.
  - On each tick, advance the phase, update position and decrement remaining.
  - A tick when remaining==1 moves to DONE.
  - cmd_valid is ignored (not accepted).
  - enable low moves to IDLE: remaining cleared, no done pulse, position and phase retained, coils 0000.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - A tick in this cycle is ignored.
- Simultaneous events:
  - A tick in the same cycle as command accept is not counted; the first counted tick is the next rising edge.
  - enable low in the same cycle as the last tick gives abort priority: no done pulse, but that final tick is still applied to phase and position.
- Coil output rules, registered and glitch-free:
  - enable=0 gives 0000.
  - In RUN or DONE, coils = table[index].
  - In IDLE with enable=1, coils = table[index] if HOLD_EN=1, else 0000.
- dir or half_step changes during RUN have no effect until the next accepted command.

Decomposition:
- Shared package step_motor_pkg holds:
  - the 8-entry phase table constant, plus a lookup function from a 3-bit index to 4 bits
  - the FSM state enum (IDLE, RUN, DONE)
  - the COIL_W=4 constant.
- No sub-module. Edge detect, FSM, phase index and position counter live in step_phase_driver.

Test Plan:
- Reset then enable=1, HOLD_EN=1 → cmd_ready=1, coils=1000, position=0, busy=0, done=0.
- cmd_steps=4, dir=1, half_step=1, four step_pulse rising edges → coils 1100,0100,0110,0010; position=4; one-cycle done pulse after the 4th tick; busy low.
- Full-step reverse from index 0: cmd_steps=3, dir=0 → index 6,4,2 (coils 0001,0010,0100); position=−6.
- cmd_steps=0 → no coil change, done pulses 1 cycle after accept, busy never high.
- cmd_steps=10, drop enable after 3 ticks → coils=0000, no done, position=3, cmd_ready=0 until enable returns; cmd_valid during RUN is never accepted.
- Wrap check: preload via 0x7FFF half-step forward ticks (or a shortened POS_W=4 build: 7 ticks then 1 more) → position wraps 7→−8; a tick coincident with accept is not counted.

Source files
------------

// File: rtl/step_phase_driver_pkg.sv
// Shared definitions for the stepper phase driver.
//   COIL_W        : width of the coil enable vector {A, B, A_n, B_n}
//   state_t       : move FSM states
//   PHASE_TABLE   : 8-entry half-step excitation sequence
//   phase_lookup  : maps a 3-bit phase index to its coil pattern
package step_motor_pkg;

   localparam int unsigned COIL_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Even entries drive one coil (wave), odd entries drive two (two-phase-on).
   localparam logic [COIL_W-1:0] PHASE_TABLE [8] = '{
      4'b1000, 4'b1100, 4'b0100, 4'b0110,
      4'b0010, 4'b0011, 4'b0001, 4'b1001
   };

   function automatic logic [COIL_W-1:0] phase_lookup(input logic [2:0] idx);
      return PHASE_TABLE[idx];
   endfunction

endpackage

// File: rtl/step_phase_driver_if.sv
// Move-command handshake between the sequencer and the phase driver.
//   cmd_valid : move request
//   cmd_ready : driver can accept a command
//   cmd_steps : number of step ticks to execute (unsigned)
//   dir       : 1 = forward, 0 = reverse (sampled at accept)
//   half_step : 1 = half-step, 0 = full-step (sampled at accept)
interface step_phase_driver_if #(
   parameter int unsigned STEPS_W = 16
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [STEPS_W-1:0] cmd_steps;
   logic               dir;
   logic               half_step;

   modport master (
      output cmd_valid, cmd_steps, dir, half_step,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_steps, dir, half_step,
      output cmd_ready
   );
endinterface

// File: rtl/step_phase_driver.sv
// Unipolar 4-wire stepper phase driver. Counts rising edges of the speed
// stage's step_pulse as ticks, walks an 8-entry half-step phase table and
// tracks absolute position in half-step units.
//   clk        : system clock
//   rst        : synchronous reset, active low
//   step_pulse : speed-stage square wave, same clock domain
//   enable     : driver enable; low aborts a move and de-energises coils
//   cmd        : move-command handshake (slave side)
//   busy       : move in progress
//   done       : one-cycle pulse on normal move completion
//   position   : signed position, half-step units, wraps
//   coils      : registered coil enables {A, B, A_n, B_n}
module step_phase_driver
   import step_motor_pkg::*;
#(
   parameter int unsigned POS_W   = 16,
   parameter int unsigned STEPS_W = 16,
   parameter bit          HOLD_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               step_pulse,
   input  logic               enable,
   step_phase_driver_if.slave cmd,
   output logic               busy,
   output logic               done,
   output logic [POS_W-1:0]   position,
   output logic [COIL_W-1:0]  coils
);

   localparam logic [STEPS_W-1:0] REM_ONE = {{(STEPS_W-1){1'b0}}, 1'b1};
   localparam logic [POS_W-1:0]   POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};
   localparam logic [POS_W-1:0]   POS_TWO = {{(POS_W-2){1'b0}}, 2'b10};

   state_t             state, state_n;
   logic [2:0]         idx, idx_n;
   logic [POS_W-1:0]   pos_n;
   logic [STEPS_W-1:0] rem, rem_n;
   logic               dir_q, dir_n;
   logic               half_q, half_n;
   logic               step_q;
   logic [COIL_W-1:0]  coils_n;

   logic               tick;
   logic               ready;
   logic               accept;
   logic [2:0]         idx_step;
   logic [POS_W-1:0]   pos_step;

   // Same clock domain as the speed stage, so a plain delayed copy suffices.
   assign tick     = step_pulse & ~step_q;
   assign ready    = rst & enable & (state == IDLE);
   assign accept   = cmd.cmd_valid & ready;
   assign idx_step = half_q ? 3'd1 : 3'd2;
   assign pos_step = half_q ? POS_ONE : POS_TWO;

   assign cmd.cmd_ready = ready;
   assign busy          = (state == RUN);
   assign done          = (state == DONE);

   always_comb begin
      state_n = state;
      idx_n   = idx;
      pos_n   = position;
      rem_n   = rem;
      dir_n   = dir_q;
      half_n  = half_q;
      coils_n = '0;

      case (state)
         IDLE: begin
            // A tick coinciding with accept is deliberately not counted.
            if (accept) begin
               dir_n   = cmd.dir;
               half_n  = cmd.half_step;
               rem_n   = cmd.cmd_steps;
               state_n = (cmd.cmd_steps == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (tick) begin
               if (dir_q) begin
                  idx_n = idx + idx_step;
                  pos_n = position + pos_step;
               end else begin
                  idx_n = idx - idx_step;
                  pos_n = position - pos_step;
               end
               rem_n = rem - REM_ONE;
               if (rem == REM_ONE) begin
                  state_n = DONE;
               end
            end
            // Abort overrides completion but keeps the step just taken.
            if (!enable) begin
               state_n = IDLE;
               rem_n   = '0;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Coils are computed from the next state so the register shows the
      // pattern that belongs to the state it is entering.
      if (enable && ((state_n != IDLE) || HOLD_EN)) begin
         coils_n = phase_lookup(idx_n);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         idx      <= '0;
         position <= '0;
         rem      <= '0;
         dir_q    <= 1'b0;
         half_q   <= 1'b0;
         step_q   <= 1'b0;
         coils    <= '0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         position <= pos_n;
         rem      <= rem_n;
         dir_q    <= dir_n;
         half_q   <= half_n;
         step_q   <= step_pulse;
         coils    <= coils_n;
      end
   end

endmodule

// File: tb/tb_step_phase_driver.sv
// Scoreboard bench for step_phase_driver. Two instances share clock, reset,
// step_pulse and enable: dut1 (POS_W=16, HOLD_EN=1) and dut2 (POS_W=4,
// HOLD_EN=0, used for the position wrap). Stimulus pushes the expected coil
// changes and done pulses; a negedge monitor pops and compares them.
module tb_step_phase_driver;
   import step_motor_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        step_pulse;
   logic        enable;
   logic        busy1, done1, busy2, done2;
   logic [15:0] pos1;
   logic [3:0]  pos2;
   logic [3:0]  coils1, coils2;

   step_phase_driver_if #(.STEPS_W(16)) if1 ();
   step_phase_driver_if #(.STEPS_W(16)) if2 ();

   step_phase_driver #(.POS_W(16), .STEPS_W(16), .HOLD_EN(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .step_pulse(step_pulse), .enable(enable),
      .cmd(if1), .busy(busy1), .done(done1), .position(pos1), .coils(coils1)
   );

   step_phase_driver #(.POS_W(4), .STEPS_W(16), .HOLD_EN(1'b0)) u_dut2 (
      .clk(clk), .rst(rst), .step_pulse(step_pulse), .enable(enable),
      .cmd(if2), .busy(busy2), .done(done2), .position(pos2), .coils(coils2)
   );

   typedef struct {
      bit          is_done;
      logic [15:0] val;
      string       tag;
   } ev_t;

   ev_t  q1[$];
   ev_t  q2[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;
   logic [3:0] last1 = 4'b0000;
   logic [3:0] last2 = 4'b0000;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push(input int d, input bit is_done, input logic [15:0] val, input string tag);
      ev_t e;
      e.is_done = is_done;
      e.val     = val;
      e.tag     = tag;
      if (d == 1) q1.push_back(e);
      else        q2.push_back(e);
   endtask

   task automatic observe(input int d, input bit is_done, input logic [15:0] val);
      ev_t e;
      bit  have;
      have = (d == 1) ? (q1.size() > 0) : (q2.size() > 0);
      if (!have) begin
         n_tests++;
         n_fail++;
         $display("FAIL dut%0d_unexpected_event: got done=%0d val=%h, required no event",
                  d, is_done, val);
         return;
      end
      e = (d == 1) ? q1.pop_front() : q2.pop_front();
      chk($sformatf("dut%0d_%s_kind", d, e.tag), 16'(is_done), 16'(e.is_done));
      chk($sformatf("dut%0d_%s_val", d, e.tag), val, e.val);
   endtask

   // Monitor: a coil change or a done pulse is a DUT output event.
   always @(negedge clk) begin
      if (mon_en) begin
         if (coils1 !== last1) begin
            observe(1, 1'b0, {12'h000, coils1});
            last1 = coils1;
         end
         if (done1 !== 1'b0) observe(1, 1'b1, pos1);
         if (coils2 !== last2) begin
            observe(2, 1'b0, {12'h000, coils2});
            last2 = coils2;
         end
         if (done2 !== 1'b0) observe(2, 1'b1, {12'h000, pos2});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      step_pulse = 1'b1;
      cyc();
      step_pulse = 1'b0;
      cyc();
   endtask

   // Presents one command for exactly one edge; afterwards dir/half_step are
   // inverted to show they are not re-sampled during the move.
   task automatic send(input int d, input logic [15:0] steps, input bit dr, input bit hs,
                       input bit with_tick);
      if (d == 1) begin
         if1.cmd_valid = 1'b1; if1.cmd_steps = steps; if1.dir = dr; if1.half_step = hs;
      end else begin
         if2.cmd_valid = 1'b1; if2.cmd_steps = steps; if2.dir = dr; if2.half_step = hs;
      end
      step_pulse = with_tick;
      cyc();
      if1.cmd_valid = 1'b0;
      if2.cmd_valid = 1'b0;
      if (d == 1) begin if1.dir = ~dr; if1.half_step = ~hs; end
      else        begin if2.dir = ~dr; if2.half_step = ~hs; end
      if (with_tick) begin
         step_pulse = 1'b0;
         cyc();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; enable = 1'b1; step_pulse = 1'b0;
      if1.cmd_valid = 1'b0; if1.cmd_steps = '0; if1.dir = 1'b0; if1.half_step = 1'b0;
      if2.cmd_valid = 1'b0; if2.cmd_steps = '0; if2.dir = 1'b0; if2.half_step = 1'b0;
      repeat (3) cyc();

      // Reset state, enable already high.
      chk("rst_cmd_ready", 16'(if1.cmd_ready), 16'h0);
      chk("rst_coils",     16'(coils1), 16'h0);
      chk("rst_busy",      16'(busy1), 16'h0);
      chk("rst_done",      16'(done1), 16'h0);
      chk("rst_position",  pos1, 16'h0);
      mon_en = 1'b1;

      // Release: holding torque at index 0.
      push(1, 1'b0, 16'h0008, "hold_idx0");
      rst = 1'b1;
      cyc();
      chk("idle_cmd_ready", 16'(if1.cmd_ready), 16'h1);
      chk("idle_coils",     16'(coils1), 16'h8);
      chk("idle_position",  pos1, 16'h0);
      chk("idle_busy",      16'(busy1), 16'h0);
      chk("idle_done",      16'(done1), 16'h0);
      chk("idle_coils2",    16'(coils2), 16'h0);

      // Half-step forward, 4 ticks.
      push(1, 1'b0, 16'h000C, "hf_1100");
      push(1, 1'b0, 16'h0004, "hf_0100");
      push(1, 1'b0, 16'h0006, "hf_0110");
      push(1, 1'b0, 16'h0002, "hf_0010");
      push(1, 1'b1, 16'h0004, "hf_done");
      send(1, 16'd4, 1'b1, 1'b1, 1'b0);
      chk("hf_busy", 16'(busy1), 16'h1);
      chk("hf_ready_run", 16'(if1.cmd_ready), 16'h0);
      repeat (4) pulse();
      chk("hf_busy_after", 16'(busy1), 16'h0);
      chk("hf_done_after", 16'(done1), 16'h0);

      // Reset back to index 0 / position 0.
      push(1, 1'b0, 16'h0000, "rst2_off");
      push(1, 1'b0, 16'h0008, "rst2_hold");
      rst = 1'b0;
      cyc();
      chk("rst2_position", pos1, 16'h0);
      rst = 1'b1;
      cyc();

      // Full-step reverse from index 0: 6, 4, 2.
      push(1, 1'b0, 16'h0001, "fr_0001");
      push(1, 1'b0, 16'h0002, "fr_0010");
      push(1, 1'b0, 16'h0004, "fr_0100");
      push(1, 1'b1, 16'hFFFA, "fr_done");
      send(1, 16'd3, 1'b0, 1'b0, 1'b0);
      repeat (3) pulse();
      chk("fr_position", pos1, 16'hFFFA);

      // Zero-length move: done one cycle after accept, never busy.
      push(1, 1'b1, 16'hFFFA, "zero_done");
      send(1, 16'd0, 1'b1, 1'b1, 1'b0);
      chk("zero_busy", 16'(busy1), 16'h0);
      cyc();
      chk("zero_busy_idle", 16'(busy1), 16'h0);

      // 10-step move aborted after 3 ticks; cmd_valid in RUN must be ignored.
      push(1, 1'b0, 16'h0006, "ab_0110");
      push(1, 1'b0, 16'h0002, "ab_0010");
      push(1, 1'b0, 16'h0003, "ab_0011");
      push(1, 1'b0, 16'h0000, "ab_off");
      send(1, 16'd10, 1'b1, 1'b1, 1'b0);
      pulse();
      if1.cmd_valid = 1'b1; if1.cmd_steps = 16'd0;
      chk("ab_ready_run", 16'(if1.cmd_ready), 16'h0);
      pulse();
      pulse();
      if1.cmd_valid = 1'b0;
      chk("ab_busy_run", 16'(busy1), 16'h1);
      enable = 1'b0;
      cyc();
      if1.cmd_valid = 1'b1; if1.cmd_steps = 16'd5;
      cyc();
      chk("ab_ready_dis", 16'(if1.cmd_ready), 16'h0);
      chk("ab_busy",      16'(busy1), 16'h0);
      chk("ab_position",  pos1, 16'hFFFD);
      if1.cmd_valid = 1'b0;
      push(1, 1'b0, 16'h0003, "ab_rehold");
      enable = 1'b1;
      cyc();
      chk("ab_ready_en", 16'(if1.cmd_ready), 16'h1);
      cyc();

      // Enable drops on the final tick: tick applied, no done.
      push(1, 1'b0, 16'h0001, "lt_0001");
      push(1, 1'b0, 16'h0000, "lt_off");
      push(1, 1'b0, 16'h0009, "lt_rehold");
      send(1, 16'd2, 1'b1, 1'b1, 1'b0);
      pulse();
      step_pulse = 1'b1;
      enable = 1'b0;
      cyc();
      step_pulse = 1'b0;
      cyc();
      chk("lt_position", pos1, 16'hFFFF);
      chk("lt_busy",     16'(busy1), 16'h0);
      enable = 1'b1;
      cyc();
      cyc();

      // dut2 (POS_W=4, no hold): tick at accept ignored, 8 ticks wrap 7 -> -8.
      push(2, 1'b0, 16'h0008, "w_run_1000");
      push(2, 1'b0, 16'h000C, "w_1100");
      push(2, 1'b0, 16'h0004, "w_0100");
      push(2, 1'b0, 16'h0006, "w_0110");
      push(2, 1'b0, 16'h0002, "w_0010");
      push(2, 1'b0, 16'h0003, "w_0011");
      push(2, 1'b0, 16'h0001, "w_0001");
      push(2, 1'b0, 16'h0009, "w_1001");
      push(2, 1'b0, 16'h0008, "w_1000");
      push(2, 1'b1, 16'h0008, "w_done");
      push(2, 1'b0, 16'h0000, "w_idle_off");
      send(2, 16'd8, 1'b1, 1'b1, 1'b1);
      chk("w_pos_after_accept", 16'(pos2), 16'h0);
      chk("w_busy", 16'(busy2), 16'h1);
      repeat (7) pulse();
      chk("w_pos_7", 16'(pos2), 16'h7);
      pulse();
      chk("w_pos_wrap", 16'(pos2), 16'h8);
      repeat (3) cyc();

      chk("dut1_idle_pos", pos1, 16'hFFFF);
      chk("q1_drained", 16'(q1.size()), 16'h0);
      chk("q2_drained", 16'(q2.size()), 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
